// File: rtl/id_ctrl_pipe_pkg.sv
// Shared encodings for the ID-stage controller: extension modes, opcodes,
// function codes, FSM states and the ID/EX control-slice payload.
package cpu_ctrl_pkg;

  localparam int unsigned EXT_W  = 3;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 6;

  // Immediate extension modes carried into EX
  typedef enum logic [EXT_W-1:0] {
    EXT_NONE  = 3'd0,
    EXT_SIGN  = 3'd1,
    EXT_ZERO  = 3'd2,
    EXT_LUI   = 3'd3,
    EXT_SHAMT = 3'd4
  } ext_sel_e;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  // Controller FSM states
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Immediate/extension slice of the ID/EX register
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  imm;
    logic [EXT_W-1:0] ext_sel;
    logic             alu_src;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_BUBBLE = '{
    valid:   1'b0,
    imm:     32'd0,
    ext_sel: EXT_NONE,
    alu_src: 1'b0
  };

endpackage

// File: rtl/id_ctrl_pipe_imm_ext_unit.sv
// Combinational decode of the IF/ID instruction into extension mode,
// extended immediate, ALU B-source select and register operand usage.
module imm_ext_unit
  import cpu_ctrl_pkg::*;
(
  input  logic [XLEN-1:0]  instr_i,
  output logic [EXT_W-1:0] ext_sel_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             alu_src_o,
  output logic             uses_rs_o,
  output logic             uses_rt_o
);

  logic [OP_W-1:0] op;
  logic [5:0]      funct;
  logic            is_shift;
  logic            is_sys;
  logic            is_branch;
  ext_sel_e        sel;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];

  // Classify the instruction and pick its extension mode
  always_comb begin
    sel       = EXT_NONE;
    is_shift  = (op == OP_RTYPE) &&
                ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA));
    is_sys    = (op == OP_RTYPE) && (funct == FN_SYSCALL);
    is_branch = (op == OP_BEQ) || (op == OP_BNE);
    case (op)
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
      OP_SLTI, OP_SLTIU, OP_LW, OP_SW:  sel = EXT_SIGN;
      OP_ANDI, OP_ORI, OP_XORI:         sel = EXT_ZERO;
      OP_LUI:                           sel = EXT_LUI;
      OP_RTYPE: if (is_shift)           sel = EXT_SHAMT;
      default:                          sel = EXT_NONE;
    endcase
  end

  // Build the extended immediate for the selected mode
  always_comb begin
    imm_o = '0;
    case (sel)
      EXT_SIGN:  imm_o = {{16{instr_i[15]}}, instr_i[15:0]};
      EXT_ZERO:  imm_o = {16'b0, instr_i[15:0]};
      EXT_LUI:   imm_o = {instr_i[15:0], 16'b0};
      EXT_SHAMT: imm_o = {27'b0, instr_i[10:6]};
      default:   imm_o = '0;
    endcase
  end

  // Branches use the immediate only for the target, not as ALU operand B
  assign ext_sel_o = sel;
  assign alu_src_o = (sel != EXT_NONE) && !is_branch;
  assign uses_rs_o = !(is_shift || is_sys || (op == OP_LUI) ||
                       (op == OP_J) || (op == OP_JAL));
  assign uses_rt_o = (op == OP_RTYPE) || is_branch || (op == OP_SW);

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID-stage controller: load-use stall, EX flush bubbles, SYSCALL halt/resume
// and the immediate/extension slice of the ID/EX register.
module id_ctrl_pipe
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned     COUNT_W   = 16,
  parameter logic [XLEN-1:0] HALT_CODE = 32'd10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    instr,
  input  logic               id_valid,
  input  logic               ex_mem_read,
  input  logic [REG_W-1:0]   ex_rt,
  input  logic               flush,
  input  logic [XLEN-1:0]    sys_v0,
  input  logic               go,
  output logic               pc_stall,
  output logic               if_id_stall,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_imm,
  output logic [EXT_W-1:0]   ex_ext_sel,
  output logic               ex_alu_src,
  output logic               halted,
  output logic [COUNT_W-1:0] stall_cnt
);

  logic [EXT_W-1:0]   dec_sel;
  logic [XLEN-1:0]    dec_imm;
  logic               dec_alu_src;
  logic               uses_rs;
  logic               uses_rt;
  logic [REG_W-1:0]   rs;
  logic [REG_W-1:0]   rt;
  logic               is_sys;
  logic               hazard;
  logic               sys_halt;
  logic               stall_c;

  state_e             state_q, state_d;
  idex_ctrl_t         idex_q, idex_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  imm_ext_unit u_imm_ext (
    .instr_i   (instr),
    .ext_sel_o (dec_sel),
    .imm_o     (dec_imm),
    .alu_src_o (dec_alu_src),
    .uses_rs_o (uses_rs),
    .uses_rt_o (uses_rt)
  );

  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign is_sys = (instr[31:26] == OP_RTYPE) && (instr[5:0] == FN_SYSCALL);

  // Load-use and halt-request detection on the instruction in ID
  assign hazard   = id_valid && ex_mem_read && (ex_rt != '0) &&
                    ((uses_rs && (rs == ex_rt)) || (uses_rt && (rt == ex_rt)));
  assign sys_halt = id_valid && is_sys && (sys_v0 == HALT_CODE);

  // Next-state, stall and ID/EX payload selection
  always_comb begin
    stall_c = 1'b0;
    idex_d  = IDEX_BUBBLE;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          idex_d = IDEX_BUBBLE;
        end else if (sys_halt) begin
          stall_c = 1'b1;
          state_d = ST_HALT;
        end else if (hazard) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + COUNT_W'(1);
        end else if (id_valid) begin
          idex_d.valid   = 1'b1;
          idex_d.imm     = dec_imm;
          idex_d.ext_sel = dec_sel;
          idex_d.alu_src = dec_alu_src;
        end
      end
      ST_HALT: begin
        if (go) begin
          // The halting SYSCALL retires as a NOP so it cannot re-halt
          idex_d.valid = 1'b1;
          state_d      = ST_RUN;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, ID/EX slice and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      idex_q  <= IDEX_BUBBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_stall    = stall_c;
  assign if_id_stall = stall_c;
  assign ex_valid    = idex_q.valid;
  assign ex_imm      = idex_q.imm;
  assign ex_ext_sel  = idex_q.ext_sel;
  assign ex_alu_src  = idex_q.alu_src;
  assign halted      = (state_q == ST_HALT);
  assign stall_cnt   = cnt_q;

endmodule
